// File: rtl/uart_tx1.sv
// uart_tx1: even-parity UART transmitter fed by a small byte FIFO.
// Frame is start, 8 data bits MSB first, parity, stop; CYCLES_PER_BIT clocks per bit.
module uart_tx1 #(
    parameter int CYCLES_PER_BIT = 14,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk_3125,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [NW-1:0] count;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          parity;
    logic          bit_end, push, pop;

    assign tx_ready = count < NW'(FIFO_DEPTH);
    assign bit_end  = cnt == CW'(CYCLES_PER_BIT - 1);
    assign push     = tx_start && tx_ready;
    // Pop from IDLE, or at the last stop-bit cycle so frames run back-to-back.
    assign pop      = (count != '0) && (state == IDLE || (state == STOP && bit_end));

    always_ff @(posedge clk_3125) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + NW'(1);
            else if (pop && !push) count <= count - NW'(1);
        end
    end

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                state   <= START;
                cnt     <= '0;
                bit_idx <= '0;
                shreg   <= mem[rd_ptr];
                parity  <= ^mem[rd_ptr];
                tx      <= 1'b0;
                tx_busy <= 1'b1;
            end else if (state != IDLE) begin
                if (!bit_end) begin
                    cnt <= cnt + CW'(1);
                    if (state == STOP && cnt == CW'(CYCLES_PER_BIT - 2)) tx_done <= 1'b1;
                end else begin
                    cnt <= '0;
                    case (state)
                        START: begin
                            state <= DATA;
                            tx    <= shreg[7];
                        end
                        DATA: begin
                            if (bit_idx == 3'd7) begin
                                state <= PARITY;
                                tx    <= parity;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                tx      <= shreg[6];
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                        default: begin
                            state   <= IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx1.sv
// Bench for uart_tx1: frame-level reference model, serial receiver on tx, directed and random traffic.
module tb_uart_tx1;
    localparam int CPB   = 14;
    localparam int DEPTH = 4;
    localparam int FRAME = 11 * CPB;

    logic       clk_3125 = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready, tx, tx_busy, tx_done;

    always #5 clk_3125 = ~clk_3125;

    uart_tx1 #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_3125(clk_3125), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of accepted bytes plus position inside the current frame.
    logic [7:0] q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] m_byte = '0;
    bit         m_act = 0;
    int         m_cyc = 0;
    int         acc = 0;

    int cyc = 0, busy_cnt = 0, done_cnt = 0, run = 0, max_run = 0, last_done = -1;

    bit          rx_on = 0;
    int          rx_c = 0, rx_n = 0;
    logic [10:0] rx_bits = '0;

    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return ^d;
        if (k >= 10) return 1'b1;
        return d[3'(8 - k)];
    endfunction

    task automatic clr_counts();
        busy_cnt = 0; done_cnt = 0; run = 0; max_run = 0; last_done = -1;
    endtask

    task automatic tick();
        bit full, fin;
        logic [7:0] d;
        @(posedge clk_3125);
        if (rst) begin
            q.delete(); exp_rx.delete();
            m_act = 0; m_cyc = 0; rx_on = 0;
        end else begin
            full = q.size() >= DEPTH;
            fin  = m_act && m_cyc == FRAME - 1;
            if (m_act && !fin) m_cyc++;
            else if (q.size() != 0) begin
                m_byte = q.pop_front(); m_act = 1; m_cyc = 0;
            end else m_act = 0;
            if (tx_start && !full) begin
                q.push_back(tx_data); exp_rx.push_back(tx_data); acc++;
            end
        end
        #1;
        cyc++;
        chk("tx",    32'(tx),       32'(m_act ? exp_bit(m_byte, m_cyc / CPB) : 1'b1));
        chk("busy",  32'(tx_busy),  32'(m_act));
        chk("done",  32'(tx_done),  32'(m_act && m_cyc == FRAME - 1));
        chk("ready", 32'(tx_ready), 32'(q.size() < DEPTH));
        if (tx_busy) begin
            busy_cnt++; run++;
            if (run > max_run) max_run = run;
        end else run = 0;
        if (tx_done) begin done_cnt++; last_done = cyc; end
        // Independent receiver: find the start edge, sample each bit mid-way.
        if (!rx_on && tx === 1'b0 && !rst) begin rx_on = 1; rx_c = 0; end
        else if (rx_on) rx_c++;
        if (rx_on && rx_c % CPB == CPB / 2) begin
            rx_bits[4'(rx_c / CPB)] = tx;
            if (rx_c / CPB == 10) begin
                rx_on = 0; rx_n++;
                for (int i = 0; i < 8; i++) d[3'(7 - i)] = rx_bits[4'(i + 1)];
                chk("rx_start",  32'(rx_bits[0]),  32'(0));
                chk("rx_parity", 32'(rx_bits[9]),  32'(^d));
                chk("rx_stop",   32'(rx_bits[10]), 32'(1));
                chk("rx_queued", 32'(exp_rx.size() != 0), 32'(1));
                if (exp_rx.size() != 0) chk("rx_byte", 32'(d), 32'(exp_rx.pop_front()));
            end
        end
    endtask

    task automatic one_frame(input logic [7:0] d, input logic [10:0] pat, input string tag);
        logic [10:0] obs;
        int start_cyc;
        obs = '0;
        tx_data = d; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        clr_counts();
        tick();
        start_cyc = cyc;
        chk({tag, "_start"}, 32'(tx), 32'(0));
        for (int c = 0; c < FRAME + 20; c++) begin
            if (c < FRAME && c % CPB == CPB / 2) obs[4'(c / CPB)] = tx;
            tick();
        end
        chk({tag, "_bits"},    32'(obs),                   32'(pat));
        chk({tag, "_ndone"},   32'(done_cnt),              32'(1));
        chk({tag, "_done_at"}, 32'(last_done - start_cyc), 32'(FRAME - 1));
        chk({tag, "_busy"},    32'(busy_cnt),              32'(FRAME));
    endtask

    initial begin
        int rx0, acc0, guard;
        rst = 1'b1; tx_start = 1'b0; tx_data = '0;
        #1;
        chk("rst_tx",    32'(tx),       32'(1));
        chk("rst_busy",  32'(tx_busy),  32'(0));
        chk("rst_done",  32'(tx_done),  32'(0));
        chk("rst_ready", 32'(tx_ready), 32'(1));
        tick(); tick();
        rst = 1'b0;

        // First push right after reset release, then a second single frame.
        one_frame(8'hA5, 11'b10101001010, "a5");
        one_frame(8'h07, 11'b11111000000, "x07");

        // Six writes on consecutive edges: sixth is dropped, five frames back-to-back.
        clr_counts();
        rx0 = rx_n;
        for (int i = 1; i <= 6; i++) begin
            tx_data = 8'(i); tx_start = 1'b1;
            if (i == 6) chk("burst_ready6", 32'(tx_ready), 32'(0));
            tick();
        end
        tx_start = 1'b0;
        for (int c = 0; c < 800; c++) tick();
        chk("burst_busy",  32'(busy_cnt),    32'(5 * FRAME));
        chk("burst_run",   32'(max_run),     32'(5 * FRAME));
        chk("burst_done",  32'(done_cnt),    32'(5));
        chk("burst_rx",    32'(rx_n - rx0),  32'(5));

        // Reset during data bit 3 of 0x3C with two bytes queued.
        tx_start = 1'b1;
        tx_data = 8'h3C; tick();
        tx_data = 8'h11; tick();
        tx_data = 8'h22; tick();
        tx_start = 1'b0;
        guard = 0;
        while (m_cyc < 4 * CPB + 6 && guard < 200) begin tick(); guard++; end
        chk("abort_reach", 32'(m_act && m_cyc / CPB == 4), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("abort_tx",    32'(tx),       32'(1));
        chk("abort_ready", 32'(tx_ready), 32'(1));
        chk("abort_busy",  32'(tx_busy),  32'(0));
        tick(); tick();
        rst = 1'b0;
        clr_counts();
        rx0 = rx_n;
        for (int c = 0; c < 2 * FRAME; c++) tick();
        chk("abort_quiet_busy", 32'(busy_cnt),   32'(0));
        chk("abort_quiet_rx",   32'(rx_n - rx0), 32'(0));

        // Push exactly on the tx_done cycle with an empty FIFO: one idle cycle between frames.
        tx_data = 8'h5A; tx_start = 1'b1; tick(); tx_start = 1'b0;
        guard = 0;
        while (!(m_act && m_cyc == FRAME - 1) && guard < 2 * FRAME) begin tick(); guard++; end
        chk("gap_done", 32'(tx_done), 32'(1));
        tx_data = 8'hC3; tx_start = 1'b1; tick(); tx_start = 1'b0;
        chk("gap_tx",    32'(tx),      32'(1));
        chk("gap_busy",  32'(tx_busy), 32'(0));
        tick();
        chk("gap_start", 32'(tx),      32'(0));
        for (int c = 0; c < FRAME + 10; c++) tick();

        // Random loopback of 256 accepted bytes.
        rx0 = rx_n; acc0 = acc; guard = 0;
        while (acc - acc0 < 256 && guard < 60000) begin
            tx_start = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            tick();
            guard++;
        end
        tx_start = 1'b0;
        chk("loop_accepted", 32'(acc - acc0), 32'(256));
        guard = 0;
        while ((m_act || q.size() != 0) && guard < 2000) begin tick(); guard++; end
        for (int c = 0; c < 20; c++) tick();
        chk("loop_rx_count", 32'(rx_n - rx0),    32'(256));
        chk("loop_rx_left",  32'(exp_rx.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
